// File: rtl/dmem_mmio_router.sv
// dmem_mmio_router: routes CPU data-port accesses either straight through to
// the memory system or to a small MMIO register block. The block holds a
// CPU-to-host mailbox FIFO, a read-only host command word and a scratch register.
module dmem_mmio_router #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = 32'hFFFF_0000,
  parameter int                    FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  // CPU side
  input  logic [ADDR_WIDTH-1:0]         cpu_addr,
  input  logic [DATA_WIDTH-1:0]         cpu_write_data,
  input  logic                          cpu_read,
  input  logic                          cpu_write,
  input  logic [3:0]                    cpu_byte_enable,
  output logic [DATA_WIDTH-1:0]         cpu_read_data,
  output logic                          cpu_ready,
  // Memory side
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_write_data,
  output logic                          mem_read,
  output logic                          mem_write,
  output logic [3:0]                    mem_byte_enable,
  input  logic [DATA_WIDTH-1:0]         mem_read_data,
  input  logic                          mem_ready,
  // Host side
  output logic [31:0]                   mbox_data,
  output logic                          mbox_valid,
  input  logic                          mbox_pop,
  output logic [$clog2(FIFO_DEPTH):0]   mbox_count,
  input  logic [31:0]                   host_cmd,
  output logic                          mmio_error
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  localparam logic [1:0] REG_MBOX_TX     = 2'd0;
  localparam logic [1:0] REG_MBOX_STATUS = 2'd1;
  localparam logic [1:0] REG_HOST_CMD    = 2'd2;
  localparam logic [1:0] REG_SCRATCH     = 2'd3;

  logic [0:0]            state;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_next;
  logic [31:0]           scratch;
  logic                  overflow;

  logic [31:0]           fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;

  // Address decode
  logic                  is_mmio;
  logic [ADDR_WIDTH-1:0] mmio_off;
  logic                  mmio_mapped;
  logic [1:0]            reg_sel;
  logic                  mmio_req;
  logic                  mmio_is_wr;

  assign is_mmio     = cpu_addr >= MMIO_BASE;
  assign mmio_off    = cpu_addr - MMIO_BASE;
  assign mmio_mapped = mmio_off < ADDR_WIDTH'(16);
  assign reg_sel     = mmio_off[3:2];
  // Decode only happens in IDLE so a held request causes one side effect.
  assign mmio_req    = is_mmio && (cpu_read || cpu_write) && (state == ST_IDLE);
  assign mmio_is_wr  = cpu_write;  // write wins when both strobes are high

  // Register side-effect strobes
  logic fifo_full, fifo_empty;
  logic push, push_ok, pop_ok, overflow_set, status_rd, scratch_wr;

  assign fifo_full    = count == CNT_W'(FIFO_DEPTH);
  assign fifo_empty   = count == '0;
  assign push         = mmio_req && mmio_mapped && mmio_is_wr && (reg_sel == REG_MBOX_TX);
  assign push_ok      = push && (!fifo_full || mbox_pop);
  assign pop_ok       = mbox_pop && !fifo_empty;
  assign overflow_set = push && fifo_full && !mbox_pop;
  assign status_rd    = mmio_req && mmio_mapped && !mmio_is_wr && (reg_sel == REG_MBOX_STATUS);
  assign scratch_wr   = mmio_req && mmio_mapped && mmio_is_wr && (reg_sel == REG_SCRATCH);

  // Memory path is forwarded unchanged; only the strobes are gated in the MMIO window.
  assign mem_addr        = cpu_addr;
  assign mem_write_data  = cpu_write_data;
  assign mem_byte_enable = cpu_byte_enable;
  assign mem_read        = cpu_read  && !is_mmio;
  assign mem_write       = cpu_write && !is_mmio;

  assign cpu_ready     = is_mmio ? (state == ST_RESP) : mem_ready;
  assign cpu_read_data = is_mmio ? rdata_q : mem_read_data;

  assign mbox_count = count;
  assign mbox_valid = !fifo_empty;
  assign mbox_data  = fifo_mem[rd_ptr];

  // Select the register value a load would return this cycle.
  always_comb begin
    // NOTE: default first so every path assigns rdata_next and no latch is inferred.
    rdata_next = '0;
    if (mmio_mapped && !mmio_is_wr) begin
      case (reg_sel)
        REG_MBOX_TX:     rdata_next = DATA_WIDTH'(count);
        REG_MBOX_STATUS: rdata_next = DATA_WIDTH'({overflow, fifo_full, fifo_empty});
        REG_HOST_CMD:    rdata_next = host_cmd;
        REG_SCRATCH:     rdata_next = scratch;
        default:         rdata_next = '0;
      endcase
    end
  end

  // Two-state access FSM: decode and latch in IDLE, respond in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state      <= ST_IDLE;
      rdata_q    <= '0;
      mmio_error <= 1'b0;
    end else begin
      mmio_error <= mmio_req && !mmio_mapped;
      case (state)
        ST_IDLE: if (mmio_req) begin
          state   <= ST_RESP;
          rdata_q <= rdata_next;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Mailbox FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the storage is reset too, because the head entry drives mbox_data and must read 0 after reset.
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        fifo_mem[wr_ptr] <= cpu_write_data[31:0];
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag, cleared by a status read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               overflow <= 1'b0;
    else if (overflow_set) overflow <= 1'b1;
    else if (status_rd)    overflow <= 1'b0;
  end

  // Scratch register with per-byte write enables.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scratch <= '0;
    end else if (scratch_wr) begin
      for (int b = 0; b < 4; b++)
        if (cpu_byte_enable[b]) scratch[8*b +: 8] <= cpu_write_data[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_dmem_mmio_router.sv
// Directed testbench for dmem_mmio_router.
module tb_dmem_mmio_router;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr, cpu_write_data, cpu_read_data;
  logic        cpu_read, cpu_write, cpu_ready;
  logic [3:0]  cpu_byte_enable;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_read, mem_write, mem_ready;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mbox_data;
  logic        mbox_valid, mbox_pop;
  logic [2:0]  mbox_count;
  logic [31:0] host_cmd;
  logic        mmio_error;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_mmio_router dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_write_data(cpu_write_data),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_byte_enable(cpu_byte_enable),
    .cpu_read_data(cpu_read_data), .cpu_ready(cpu_ready),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
    .mem_read_data(mem_read_data), .mem_ready(mem_ready),
    .mbox_data(mbox_data), .mbox_valid(mbox_valid), .mbox_pop(mbox_pop),
    .mbox_count(mbox_count), .host_cmd(host_cmd), .mmio_error(mmio_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One complete MMIO access. Inputs change at the negedge, outputs are sampled
  // at the following negedge (RESP cycle), and the request drops just after the
  // edge that ends RESP.
  task automatic mmio_access(input string tag, input logic [31:0] addr, input logic rd,
                             input logic wr, input logic [31:0] wdata, input logic [3:0] be,
                             input logic pop, output logic [31:0] rdata, output logic err);
    @(negedge clk);
    cpu_addr = addr; cpu_read = rd; cpu_write = wr;
    cpu_write_data = wdata; cpu_byte_enable = be; mbox_pop = pop;
    #1;
    check({tag, " ready_before"}, {31'b0, cpu_ready}, 32'd0);
    check({tag, " mem_strobes"}, {30'b0, mem_read, mem_write}, 32'd0);
    @(posedge clk);
    #1 mbox_pop = 1'b0;
    @(negedge clk);
    check({tag, " ready_resp"}, {31'b0, cpu_ready}, 32'd1);
    rdata = cpu_read_data;
    err   = mmio_error;
    @(posedge clk);
    #1 cpu_read = 1'b0; cpu_write = 1'b0;
    check({tag, " ready_after"}, {31'b0, cpu_ready}, 32'd0);
    check({tag, " err_after"}, {31'b0, mmio_error}, 32'd0);
  endtask

  task automatic host_pop();
    @(negedge clk) mbox_pop = 1'b1;
    @(posedge clk);
    #1 mbox_pop = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;

    rst = 1'b1; cpu_addr = 32'hFFFF_0000; cpu_write_data = '0;
    cpu_read = 1'b0; cpu_write = 1'b0; cpu_byte_enable = 4'h0;
    mem_read_data = '0; mem_ready = 1'b0; mbox_pop = 1'b0; host_cmd = 32'hDEAD_BEEF;

    // Reset state
    #1;
    check("rst count", {29'b0, mbox_count}, 32'd0);
    check("rst valid", {31'b0, mbox_valid}, 32'd0);
    check("rst data", mbox_data, 32'd0);
    check("rst err", {31'b0, mmio_error}, 32'd0);
    check("rst ready", {31'b0, cpu_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Memory pass-through load with two wait cycles
    @(negedge clk);
    cpu_addr = 32'h100; cpu_read = 1'b1; mem_read_data = 32'h1234;
    #1;
    check("mem_read fwd", {31'b0, mem_read}, 32'd1);
    check("mem_addr fwd", mem_addr, 32'h100);
    for (int i = 0; i < 2; i++) begin
      check("mem wait ready", {31'b0, cpu_ready}, 32'd0);
      @(negedge clk);
    end
    mem_ready = 1'b1;
    #1;
    check("mem ready follow", {31'b0, cpu_ready}, 32'd1);
    check("mem rdata", cpu_read_data, 32'h1234);
    check("mem count", {29'b0, mbox_count}, 32'd0);
    @(negedge clk);
    cpu_read = 1'b0; mem_ready = 1'b0;
    // Memory pass-through store
    cpu_addr = 32'h200; cpu_write = 1'b1; cpu_write_data = 32'h5555_AAAA; cpu_byte_enable = 4'h3;
    #1;
    check("mem_write fwd", {31'b0, mem_write}, 32'd1);
    check("mem_wdata fwd", mem_write_data, 32'h5555_AAAA);
    check("mem_be fwd", {28'b0, mem_byte_enable}, 32'h3);
    @(negedge clk) cpu_write = 1'b0;

    // Mailbox fill and overflow
    for (int i = 0; i < 5; i++) begin
      mmio_access("fill", 32'hFFFF_0000, 1'b0, 1'b1, 32'hA0 + i, 4'h0, 1'b0, rd, er);
      check("fill err", {31'b0, er}, 32'd0);
    end
    check("fill count", {29'b0, mbox_count}, 32'd4);
    check("fill head", mbox_data, 32'hA0);
    mmio_access("tx rd", 32'hFFFF_0000, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, rd, er);
    check("tx rd count", rd, 32'd4);
    mmio_access("stat1", 32'hFFFF_0004, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, rd, er);
    check("stat overflow", rd, 32'h6);
    mmio_access("stat2", 32'hFFFF_0004, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, rd, er);
    check("stat cleared", rd, 32'h2);

    // Drain and wrap
    for (int i = 0; i < 4; i++) begin
      check("drain head", mbox_data, 32'hA0 + i);
      host_pop();
    end
    check("drain valid", {31'b0, mbox_valid}, 32'd0);
    host_pop();
    check("empty pop count", {29'b0, mbox_count}, 32'd0);
    mmio_access("stat empty", 32'hFFFF_0004, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, rd, er);
    check("stat empty", rd, 32'h1);
    mmio_access("push B0", 32'hFFFF_0000, 1'b0, 1'b1, 32'hB0, 4'hF, 1'b0, rd, er);
    check("wrap head", mbox_data, 32'hB0);
    check("wrap valid", {31'b0, mbox_valid}, 32'd1);

    // Simultaneous push and pop while full
    for (int i = 1; i < 4; i++)
      mmio_access("push B", 32'hFFFF_0000, 1'b0, 1'b1, 32'hB0 + i, 4'hF, 1'b0, rd, er);
    check("full count", {29'b0, mbox_count}, 32'd4);
    mmio_access("push C0", 32'hFFFF_0000, 1'b0, 1'b1, 32'hC0, 4'hF, 1'b1, rd, er);
    check("pushpop count", {29'b0, mbox_count}, 32'd4);
    mmio_access("stat pushpop", 32'hFFFF_0004, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, rd, er);
    check("stat no overflow", rd, 32'h2);
    begin
      logic [31:0] exp_q [4] = '{32'hB1, 32'hB2, 32'hB3, 32'hC0};
      for (int i = 0; i < 4; i++) begin
        check("pushpop order", mbox_data, exp_q[i]);
        host_pop();
      end
    end
    check("pushpop drained", {29'b0, mbox_count}, 32'd0);

    // Writes to read-only registers do not push or change anything
    mmio_access("wr status", 32'hFFFF_0004, 1'b0, 1'b1, 32'h77, 4'hF, 1'b0, rd, er);
    mmio_access("wr hostcmd", 32'hFFFF_0008, 1'b0, 1'b1, 32'h77, 4'hF, 1'b0, rd, er);
    check("ro count", {29'b0, mbox_count}, 32'd0);
    mmio_access("rd hostcmd", 32'hFFFF_0008, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, rd, er);
    check("host_cmd", rd, 32'hDEAD_BEEF);

    // SCRATCH byte enables
    mmio_access("scr rd0", 32'hFFFF_000C, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, rd, er);
    check("scratch reset", rd, 32'h0);
    mmio_access("scr wrF", 32'hFFFF_000C, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0, rd, er);
    mmio_access("scr wr5", 32'hFFFF_000C, 1'b0, 1'b1, 32'h0000_0000, 4'h5, 1'b0, rd, er);
    mmio_access("scr rd1", 32'hFFFF_000C, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, rd, er);
    check("scratch lanes", rd, 32'hFF00_FF00);
    // Read and write together behave as a write
    mmio_access("scr rw", 32'hFFFF_000C, 1'b1, 1'b1, 32'h1234_5678, 4'hF, 1'b0, rd, er);
    mmio_access("scr rd2", 32'hFFFF_000C, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, rd, er);
    check("rw is write", rd, 32'h1234_5678);

    // Unmapped offsets
    mmio_access("unmap rd", 32'hFFFF_0010, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, rd, er);
    check("unmap data", rd, 32'h0);
    check("unmap err", {31'b0, er}, 32'd1);
    mmio_access("unmap wr", 32'hFFFF_0020, 1'b0, 1'b1, 32'hEE, 4'hF, 1'b0, rd, er);
    check("unmap wr err", {31'b0, er}, 32'd1);
    check("unmap wr count", {29'b0, mbox_count}, 32'd0);

    // Reset asserted during the RESP of a push
    @(negedge clk);
    cpu_addr = 32'hFFFF_0000; cpu_write = 1'b1; cpu_write_data = 32'hD0; cpu_byte_enable = 4'hF;
    @(posedge clk);
    #1;
    check("resp push count", {29'b0, mbox_count}, 32'd1);
    check("resp ready", {31'b0, cpu_ready}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst resp count", {29'b0, mbox_count}, 32'd0);
    check("rst resp ready", {31'b0, cpu_ready}, 32'd0);
    check("rst resp valid", {31'b0, mbox_valid}, 32'd0);
    cpu_write = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    check("post rst ready", {31'b0, cpu_ready}, 32'd0);
    check("post rst count", {29'b0, mbox_count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
